stack: RTL and testbench
========================

// Module: stack
// PURPOSE
//   LIFO stack of WIDTH-bit words, DEPTH entries deep. Used by the 8-Queen solver as
//   its backtracking store: each word packs a {row[2:0], col[2:0]} placement.
//   The top-of-stack word is always visible on out_data.
//   Push and pop are level-qualified, one operation per clock edge.
// PARAMETERS
//   DEPTH  8  number of entries (any value >= 2; not required to be a power of 2)
//   WIDTH  6  data word width in bits
// PORTS
//   clk       in   1      clock; all state updates on rising edge
//   reset     in   1      asynchronous, active-low reset
//   push      in   1      write in_data on top at next rising edge
//   in_data   in   WIDTH  word to push
//   pop       in   1      remove top word at next rising edge
//   out_data  out  WIDTH  current top-of-stack word; 0 when empty
//   full      out  1      count == DEPTH
//   empty     out  1      count == 0
//   Positional port order is exactly as listed above; full/empty are last.
// BEHAVIOUR
//   - State: mem[0..DEPTH-1] and sp (count of valid entries, $clog2(DEPTH)+1 bits).
//   - Reset (reset==0, async): sp=0, all mem entries 0. Outputs: out_data=0, empty=1, full=0.
//     Reset asserted mid-operation discards all content immediately.
//   - Per rising edge with reset==1:
//       push & !pop & !full   : mem[sp] <= in_data; sp <= sp+1
//       push & !pop & full    : ignored, no state change (overflow dropped)
//       pop & !push & !empty  : sp <= sp-1; the vacated entry is left unchanged
//       pop & !push & empty   : ignored (underflow dropped)
//       push & pop & !empty   : replace top: mem[sp-1] <= in_data; sp unchanged
//       push & pop & empty    : acts as push (sp <= 1)
//       neither               : hold
//   - out_data is combinational from registered state: mem[sp-1] if sp>0, else 0.
//     It reflects a push or pop in the same cycle the edge occurs (zero extra latency).
//   - full and empty are combinational decodes of sp.
//   - Inputs are sampled only at rising edges; pulse width is irrelevant as long as
//     the pulse covers exactly one rising edge.
//   - No wrap-around: sp saturates within 0..DEPTH.
// STRUCTURE
//   - Shared package (queen_pkg): STACK_DEPTH=8, STACK_WIDTH=6, and the
//     placement_t = {row[2:0], col[2:0]} packing used by the solver.
//   - Single flat module. Storage array and sp counter are inline; no sub-module.
// TESTING
//   1. Hold reset=0 for 20 ns, then release -> out_data=0, empty=1, full=0.
//   2. Push 6'o00 (one edge), then push 6'o16 ({3'd1,3'd6}) -> out_data=6'o16,
//      sp=2, empty=0.
//   3. Pop once -> out_data=6'o00. Pop again -> empty=1, out_data=0.
//      Third pop -> no change (underflow ignored).
//   4. Push 1..8 -> full=1, out_data=8. Push 9 -> ignored, out_data=8.
//      Pop 8 times -> data returned 8..1 in LIFO order.
//   5. With stack holding [3,5], assert push & pop with in_data=7 -> out_data=7,
//      sp=2. Then pop -> out_data=3.
//   6. Push 3 words, then assert reset=0 between clock edges -> out_data=0 and
//      empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/queen_pkg.sv
// queen_pkg: shared sizes and placement packing for the 8-Queen solver
package queen_pkg;
    localparam int STACK_DEPTH = 8;
    localparam int STACK_WIDTH = 6;
    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } placement_t;
    function automatic placement_t place(input logic [2:0] row, input logic [2:0] col);
        return '{row: row, col: col};
    endfunction
endpackage

// File: rtl/stack.sv
// stack: LIFO backtracking store, top word always visible on out_data
module stack
    import queen_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = STACK_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] in_data,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             empty
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;
    logic [AW-1:0]    top_idx, wr_idx;
    logic             wr, inc, dec;
    always_comb begin
        full     = sp == SPW'(DEPTH);
        empty    = sp == '0;
        top_idx  = AW'(sp - SPW'(1));
        out_data = empty ? '0 : mem[top_idx];
        // push&pop on a non-empty stack overwrites the top in place
        wr       = push && (pop || !full);
        wr_idx   = (pop && !empty) ? top_idx : AW'(sp);
        inc      = push && !full && (!pop || empty);
        dec      = pop && !push && !empty;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) mem[wr_idx] <= in_data;
            sp <= inc ? sp + SPW'(1) : dec ? sp - SPW'(1) : sp;
        end
endmodule

// File: tb/tb_stack.sv
// tb_stack: directed scoreboard bench for the LIFO stack
module tb_stack;
    logic       clk = 0;
    logic       reset = 0;
    logic       push = 0;
    logic       pop = 0;
    logic [5:0] in_data = '0;
    logic [5:0] out_data;
    logic       full, empty;

    typedef struct {
        string      name;
        logic [5:0] d;
        logic       f;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    stack dut (
        .clk(clk), .reset(reset), .push(push), .in_data(in_data),
        .pop(pop), .out_data(out_data), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Monitor: after each clock edge or reset assertion, check every pending expectation
    initial forever begin
        @(posedge clk or negedge reset);
        #1;
        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            vectors++;
            if (out_data !== x.d || full !== x.f || empty !== x.e) begin
                miscompares++;
                $display("FAIL %s: got out_data=%0d full=%b empty=%b, want out_data=%0d full=%b empty=%b",
                         x.name, out_data, full, empty, x.d, x.f, x.e);
            end
        end
    end

    task automatic op(input logic p, input logic q, input logic [5:0] d, input string nm,
                      input logic [5:0] ed, input logic ef, input logic ee);
        @(negedge clk);
        push = p;
        pop = q;
        in_data = d;
        sb.push_back('{nm, ed, ef, ee});
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        push = 0;
        pop = 0;
        in_data = '0;
    endtask

    task automatic async_reset(input string nm);
        idle_inputs();
        @(posedge clk);
        #2;
        sb.push_back('{nm, 6'd0, 1'b0, 1'b1});
        reset = 0;
        #2;
        reset = 1;
    endtask

    initial begin
        #20 reset = 1;
        op(0, 0, 0, "reset_state", 0, 0, 1);
        op(1, 0, 6'o00, "push_o00", 6'o00, 0, 0);
        op(1, 0, 6'o16, "push_o16", 6'o16, 0, 0);
        op(0, 1, 0, "pop_to_o00", 6'o00, 0, 0);
        op(0, 1, 0, "pop_to_empty", 0, 0, 1);
        op(0, 1, 0, "underflow", 0, 0, 1);
        for (int i = 1; i <= 8; i++)
            op(1, 0, 6'(i), $sformatf("fill_%0d", i), 6'(i), i == 8, 0);
        op(1, 0, 6'd9, "overflow", 6'd8, 1, 0);
        for (int k = 1; k <= 8; k++)
            op(0, 1, 0, $sformatf("drain_%0d", k), 6'(8 - k), 0, k == 8);
        op(1, 0, 6'd3, "push_3", 6'd3, 0, 0);
        op(1, 0, 6'd5, "push_5", 6'd5, 0, 0);
        op(1, 1, 6'd7, "replace_top", 6'd7, 0, 0);
        op(0, 1, 0, "pop_after_replace", 6'd3, 0, 0);
        op(0, 1, 0, "pop_last", 0, 0, 1);
        op(1, 1, 6'd9, "pushpop_empty", 6'd9, 0, 0);
        op(0, 1, 0, "pop_pushpop", 0, 0, 1);
        for (int i = 1; i <= 8; i++)
            op(1, 0, 6'(10 + i), $sformatf("refill_%0d", i), 6'(10 + i), i == 8, 0);
        op(1, 1, 6'd33, "replace_full", 6'd33, 1, 0);
        op(0, 1, 0, "pop_from_full", 6'd17, 0, 0);
        async_reset("flush_full");
        op(1, 0, 6'd1, "push_a", 6'd1, 0, 0);
        op(1, 0, 6'd2, "push_b", 6'd2, 0, 0);
        op(1, 0, 6'd3, "push_c", 6'd3, 0, 0);
        async_reset("async_reset");
        op(0, 0, 0, "after_reset", 0, 0, 1);
        op(0, 1, 0, "pop_after_reset", 0, 0, 1);
        op(1, 0, 6'd4, "push_after_reset", 6'd4, 0, 0);
        idle_inputs();
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1);
    end
endmodule
